// File: rtl/stream_comparator_win_if.sv
// Operand/result/statistics bundle for stream_comparator_win.
// master drives operands and result backpressure; slave is the comparator.
interface stream_comparator_win_if #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
);
  localparam int CW = $clog2(WINDOW + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             lesser;
  logic             greater;
  logic             equal;
  logic             win_valid;
  logic [CW-1:0]    win_lt;
  logic [CW-1:0]    win_gt;
  logic [CW-1:0]    win_eq;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, lesser, greater, equal,
    input  win_valid, win_lt, win_gt, win_eq
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, lesser, greater, equal,
    output win_valid, win_lt, win_gt, win_eq
  );
endinterface

// File: rtl/stream_comparator_win.sv
// Streaming magnitude comparator with a one-deep registered result stage and
// per-window lt/gt/eq outcome counters published as a snapshot every WINDOW accepts.
module stream_comparator_win #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int WINDOW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  stream_comparator_win_if.slave s
);
  localparam int            CW   = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_t;

  typedef struct packed {
    logic [CW-1:0] lt;
    logic [CW-1:0] gt;
    logic [CW-1:0] eq;
  } cnt_t;

  logic          out_valid_q, out_valid_d;
  cmp_t          res_q, res_d;
  cnt_t          cnt_q, cnt_d;
  cnt_t          snap_q, snap_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          win_valid_q, win_valid_d;

  logic accept;
  logic a_lt_b;
  logic a_gt_b;

  always_comb begin
    if (SIGNED != 0) begin
      a_lt_b = $signed(s.a) < $signed(s.b);
      a_gt_b = $signed(s.a) > $signed(s.b);
    end else begin
      a_lt_b = s.a < s.b;
      a_gt_b = s.a > s.b;
    end
  end

  // A result leaving this cycle frees the stage for a new pair in the same cycle.
  assign s.in_ready = !out_valid_q || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    win_valid_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      res_d.lt    = a_lt_b;
      res_d.gt    = a_gt_b;
      res_d.eq    = !a_lt_b && !a_gt_b;
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end

    // clr outranks a simultaneous accept: the pair still produces a result but is not counted.
    if (clr) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (accept) begin
      cnt_d.lt = cnt_q.lt + (res_d.lt ? ONE : '0);
      cnt_d.gt = cnt_q.gt + (res_d.gt ? ONE : '0);
      cnt_d.eq = cnt_q.eq + (res_d.eq ? ONE : '0);
      if (idx_q == LAST) begin
        snap_d      = cnt_d;
        win_valid_d = 1'b1;
        cnt_d       = '0;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + ONE;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      snap_q      <= '0;
      idx_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.lesser    = res_q.lt;
  assign s.greater   = res_q.gt;
  assign s.equal     = res_q.eq;
  assign s.win_valid = win_valid_q;
  assign s.win_lt    = snap_q.lt;
  assign s.win_gt    = snap_q.gt;
  assign s.win_eq    = snap_q.eq;
endmodule

// File: tb/tb_stream_comparator_win.sv
// Directed bench: unsigned WINDOW=4, signed WINDOW=4 and unsigned WINDOW=1 instances
// driven in lockstep with identical stimulus.
module tb_stream_comparator_win;
  logic clk;
  logic rst_n;
  logic clr;

  int n_checks;
  int n_pass;

  stream_comparator_win_if #(.WIDTH(8), .WINDOW(4)) ifu ();
  stream_comparator_win_if #(.WIDTH(8), .WINDOW(4)) ifs ();
  stream_comparator_win_if #(.WIDTH(8), .WINDOW(1)) ifw ();

  stream_comparator_win #(.WIDTH(8), .SIGNED(0), .WINDOW(4)) u_uns (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(ifu)
  );
  stream_comparator_win #(.WIDTH(8), .SIGNED(1), .WINDOW(4)) u_sgn (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(ifs)
  );
  stream_comparator_win #(.WIDTH(8), .SIGNED(0), .WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(ifw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic ordy, input logic c);
    ifu.in_valid = v; ifu.a = av; ifu.b = bv; ifu.out_ready = ordy;
    ifs.in_valid = v; ifs.a = av; ifs.b = bv; ifs.out_ready = ordy;
    ifw.in_valid = v; ifw.a = av; ifw.b = bv; ifw.out_ready = ordy;
    clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick(); tick();
    n_checks++; if (ifu.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ifu.out_valid); else n_pass++;
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if (ifu.win_valid !== 1'b0) $display("FAIL rst_win_valid got %b exp 0", ifu.win_valid); else n_pass++;
    n_checks++; if ({ifu.win_lt, ifu.win_gt, ifu.win_eq} !== 9'd0) $display("FAIL rst_win_counts got %h exp 0", {ifu.win_lt, ifu.win_gt, ifu.win_eq}); else n_pass++;
    n_checks++; if (ifu.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", ifu.in_ready); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    drive(1'b1, 8'd5, 8'd9, 1'b1, 1'b0); tick();
    n_checks++; if (ifu.out_valid !== 1'b1) $display("FAIL uns_valid got %b exp 1", ifu.out_valid); else n_pass++;
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b100) $display("FAIL uns_5_9 got %b exp 100", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if ({ifw.win_valid, ifw.win_lt, ifw.win_gt, ifw.win_eq} !== 4'b1100) $display("FAIL w1_snap_lt got %b exp 1100", {ifw.win_valid, ifw.win_lt, ifw.win_gt, ifw.win_eq}); else n_pass++;
    drive(1'b1, 8'd9, 8'd5, 1'b1, 1'b0); tick();
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b010) $display("FAIL uns_9_5 got %b exp 010", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if ({ifw.win_valid, ifw.win_lt, ifw.win_gt, ifw.win_eq} !== 4'b1010) $display("FAIL w1_snap_gt got %b exp 1010", {ifw.win_valid, ifw.win_lt, ifw.win_gt, ifw.win_eq}); else n_pass++;
    drive(1'b1, 8'd7, 8'd7, 1'b1, 1'b0); tick();
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b001) $display("FAIL uns_7_7 got %b exp 001", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if (ifu.win_valid !== 1'b0) $display("FAIL uns_no_early_snap got %b exp 0", ifu.win_valid); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
    n_checks++; if (ifu.out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", ifu.out_valid); else n_pass++;
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b001) $display("FAIL drain_flags_hold got %b exp 001", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if (ifw.win_valid !== 1'b0) $display("FAIL w1_pulse_end got %b exp 0", ifw.win_valid); else n_pass++;
  endtask

  // Fourth accept since reset: completes the first window of both WINDOW=4 instances.
  task automatic test_signed();
    drive(1'b1, 8'h80, 8'h7F, 1'b1, 1'b0); tick();
    n_checks++; if ({ifu.lesser, ifu.greater, ifu.equal} !== 3'b010) $display("FAIL uns_80_7f got %b exp 010", {ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    n_checks++; if ({ifs.lesser, ifs.greater, ifs.equal} !== 3'b100) $display("FAIL sgn_80_7f got %b exp 100", {ifs.lesser, ifs.greater, ifs.equal}); else n_pass++;
    n_checks++; if ({ifu.win_valid, ifu.win_lt, ifu.win_gt, ifu.win_eq} !== {1'b1, 3'd1, 3'd2, 3'd1}) $display("FAIL uns_snap1 got %h exp %h", {ifu.win_valid, ifu.win_lt, ifu.win_gt, ifu.win_eq}, {1'b1, 3'd1, 3'd2, 3'd1}); else n_pass++;
    n_checks++; if ({ifs.win_valid, ifs.win_lt, ifs.win_gt, ifs.win_eq} !== {1'b1, 3'd2, 3'd1, 3'd1}) $display("FAIL sgn_snap1 got %h exp %h", {ifs.win_valid, ifs.win_lt, ifs.win_gt, ifs.win_eq}, {1'b1, 3'd2, 3'd1, 3'd1}); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
    n_checks++; if (ifu.win_valid !== 1'b0) $display("FAIL snap_pulse_width got %b exp 0", ifu.win_valid); else n_pass++;
    n_checks++; if (ifu.win_gt !== 3'd2) $display("FAIL snap_hold got %0d exp 2", ifu.win_gt); else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    drive(1'b1, 8'd1, 8'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ifu.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", i, ifu.in_ready); else n_pass++;
      n_checks++; if ({ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal} !== 4'b1100) $display("FAIL bp_hold[%0d] got %b exp 1100", i, {ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
      tick();
    end
    drive(1'b1, 8'd3, 8'd3, 1'b1, 1'b0);
    n_checks++; if (ifu.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", ifu.in_ready); else n_pass++;
    tick();
    n_checks++; if ({ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal} !== 4'b1001) $display("FAIL bp_next_pair got %b exp 1001", {ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal}); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_back_to_back_window();
    logic [7:0] va [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
    logic [7:0] vb [4] = '{8'd2, 8'd1, 8'd3, 8'd9};
    logic [2:0] vf [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], 1'b1, 1'b0); tick();
      n_checks++; if ({ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal} !== {1'b1, vf[i]}) $display("FAIL b2b_flags[%0d] got %b exp %b", i, {ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal}, {1'b1, vf[i]}); else n_pass++;
      n_checks++; if (ifu.win_valid !== (i == 3)) $display("FAIL b2b_win_valid[%0d] got %b exp %b", i, ifu.win_valid, (i == 3)); else n_pass++;
    end
    n_checks++; if ({ifu.win_lt, ifu.win_gt, ifu.win_eq} !== {3'd2, 3'd1, 3'd1}) $display("FAIL b2b_counts got %h exp %h", {ifu.win_lt, ifu.win_gt, ifu.win_eq}, {3'd2, 3'd1, 3'd1}); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
    n_checks++; if ({ifu.win_valid, ifu.win_lt} !== {1'b0, 3'd2}) $display("FAIL b2b_after got %h exp %h", {ifu.win_valid, ifu.win_lt}, {1'b0, 3'd2}); else n_pass++;
  endtask

  task automatic test_clr();
    logic [7:0] va [4] = '{8'd2, 8'd2, 8'd4, 8'd0};
    logic [7:0] vb [4] = '{8'd1, 8'd1, 8'd4, 8'd1};
    drive(1'b1, 8'd1, 8'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd1, 8'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b1); tick();
    n_checks++; if ({ifu.out_valid, ifu.equal} !== 2'b11) $display("FAIL clr_pair_flows got %b exp 11", {ifu.out_valid, ifu.equal}); else n_pass++;
    n_checks++; if (ifu.win_valid !== 1'b0) $display("FAIL clr_no_pulse got %b exp 0", ifu.win_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], 1'b1, 1'b0); tick();
      n_checks++; if (ifu.win_valid !== (i == 3)) $display("FAIL clr_win_valid[%0d] got %b exp %b", i, ifu.win_valid, (i == 3)); else n_pass++;
    end
    n_checks++; if ({ifu.win_lt, ifu.win_gt, ifu.win_eq} !== {3'd1, 3'd2, 3'd1}) $display("FAIL clr_counts got %h exp %h", {ifu.win_lt, ifu.win_gt, ifu.win_eq}, {3'd1, 3'd2, 3'd1}); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'd1, 8'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd2, 8'd1, 1'b0, 1'b0); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal, ifu.win_valid} !== 5'b0) $display("FAIL midrst_outputs got %b exp 00000", {ifu.out_valid, ifu.lesser, ifu.greater, ifu.equal, ifu.win_valid}); else n_pass++;
    n_checks++; if ({ifu.win_lt, ifu.win_gt, ifu.win_eq} !== 9'd0) $display("FAIL midrst_counts got %h exp 0", {ifu.win_lt, ifu.win_gt, ifu.win_eq}); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 8'd9, 8'd1, 1'b1, 1'b0);
      else       drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
      tick();
      n_checks++; if (ifu.win_valid !== (i == 3)) $display("FAIL postrst_win_valid[%0d] got %b exp %b", i, ifu.win_valid, (i == 3)); else n_pass++;
    end
    n_checks++; if ({ifu.win_lt, ifu.win_gt, ifu.win_eq} !== {3'd0, 3'd3, 3'd1}) $display("FAIL postrst_counts got %h exp %h", {ifu.win_lt, ifu.win_gt, ifu.win_eq}, {3'd0, 3'd3, 3'd1}); else n_pass++;
    drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0); tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_back_to_back_window();
    test_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
